// File: rtl/ibus_prefetch_pkg.sv
// Shared bus widths and reset PC for the instruction prefetch stage.
`ifndef IBUS_PREFETCH_DEFINES
`define IBUS_PREFETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`define IBUS_RESET_PC 32'h8000_0000
`endif

package ibus_prefetch_pkg;
    localparam logic [`InstAddrBus] RESET_PC_DEF = `IBUS_RESET_PC;
    localparam logic [`InstBus]     INST_NOP     = '0;
    localparam int INST_ADDR_W = $bits(RESET_PC_DEF);
    localparam int INST_W      = $bits(INST_NOP);
    localparam int PC_STEP     = 4;
endpackage

// File: rtl/ibus_prefetch_if.sv
// Core fetch port, redirect and instruction-memory handshake of the prefetch stage.
interface ibus_prefetch_if #(
    parameter int ADDR_W = ibus_prefetch_pkg::INST_ADDR_W,
    parameter int DATA_W = ibus_prefetch_pkg::INST_W
);
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_ready_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    // master: the prefetch stage; slave: core plus memory environment
    modport master (
        input  redirect_i, redirect_pc_i, inst_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output inst_valid_o, inst_o, inst_pc_o, mem_req_o, mem_addr_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, inst_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  inst_valid_o, inst_o, inst_pc_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/ibus_prefetch_sync_fifo.sv
// Small single-clock FIFO with flush and occupancy count; reads 0 when empty.
module ibus_prefetch_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && (count_q != DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/ibus_prefetch.sv
// Sequential instruction prefetcher: issues word fetches ahead of the core and
// buffers {pc, inst} pairs; a redirect flushes the buffer and drops in-flight data.
module ibus_prefetch
    import ibus_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input logic            clk,
    input logic            rst,
    ibus_prefetch_if.master bus
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     inflight;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               grant;
    logic               rvalid;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    assign redirect_pc = bus.redirect_pc_i & ~ADDR_W'(3);

    // Buffered plus in-flight never exceeds DEPTH, so a response always has room.
    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign bus.mem_req_o  = !rst && (inflight < DEPTH_C);
    assign bus.mem_addr_o = req_pc_q;

    assign grant     = bus.mem_req_o && bus.mem_gnt_i;
    assign rvalid    = bus.mem_rvalid_i;
    assign fifo_push = rvalid && (discard_q == '0) && !bus.redirect_i;
    assign fifo_pop  = bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({grant, rvalid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        // On redirect everything still owed by memory becomes stale, including
        // this cycle's grant; this cycle's response is already accounted for.
        discard_d = discard_q;
        if (bus.redirect_i) begin
            discard_d = outstanding_d;
        end else if (rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        req_pc_d = req_pc_q;
        if (bus.redirect_i) begin
            req_pc_d = redirect_pc;
        end else if (grant) begin
            req_pc_d = req_pc_q + PC_INC;
        end

        resp_pc_d = resp_pc_q;
        if (bus.redirect_i) begin
            resp_pc_d = redirect_pc;
        end else if (fifo_push) begin
            resp_pc_d = resp_pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ibus_prefetch_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_sync_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  ({resp_pc_q, bus.mem_rdata_i}),
        .pop_i   (fifo_pop),
        .flush_i (bus.redirect_i),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.inst_valid_o = !fifo_empty;
    assign bus.inst_o       = fifo_head[DATA_W-1:0];
    assign bus.inst_pc_o    = fifo_head[ENTRY_W-1:DATA_W];
endmodule

// File: tb/tb_ibus_prefetch.sv
// Scoreboard bench for ibus_prefetch: a latency-programmable memory model feeds
// expected {pc, inst} pairs into a queue that is checked at every core pop.
module tb_ibus_prefetch;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibus_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ibus_prefetch #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t pend_q[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int epoch    = 0;
    int lat      = 1;

    logic        rst_cfg = 1'b1;
    logic        gnt_cfg = 1'b0;
    logic        ready_cfg = 1'b0;
    logic        redir_cfg = 1'b0;
    logic [31:0] redir_pc_cfg = '0;
    logic [31:0] model_pc = RST_PC;

    logic        s_req, s_valid, s_grant, s_pop;
    logic [31:0] s_addr, s_inst, s_pc;
    int          s_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, record what the
    // next rising edge will commit.
    task automatic step();
        req_t r;
        exp_t e;
        @(negedge clk);
        rst               = rst_cfg;
        bus.redirect_i    = redir_cfg;
        bus.redirect_pc_i = redir_pc_cfg;
        bus.inst_ready_i  = ready_cfg;
        bus.mem_gnt_i     = gnt_cfg;
        if (!rst_cfg && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = mem_word(pend_q[0].addr);
        end else begin
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        s_cyc   = cyc;
        s_req   = bus.mem_req_o;
        s_addr  = bus.mem_addr_o;
        s_valid = bus.inst_valid_o;
        s_inst  = bus.inst_o;
        s_pc    = bus.inst_pc_o;
        s_grant = s_req && gnt_cfg;
        s_pop   = s_valid && ready_cfg && !redir_cfg && !rst_cfg;
        if (rst_cfg) begin
            pend_q.delete();
            exp_q.delete();
            model_pc = RST_PC;
            epoch++;
        end else begin
            if (bus.mem_rvalid_i) check("rv_outst", 64'(dut.outstanding_q != '0), 64'd1);
            if (dut.fifo_push) check("push_full", 64'(dut.fifo_count != DEPTH), 64'd1);
            if (s_pop) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexp", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", 64'(s_pc), 64'(e.pc));
                    check("pop_inst", 64'(s_inst), 64'(e.inst));
                    $display("pop  cyc=%0d pc=%08h inst=%08h", s_cyc, s_pc, s_inst);
                end
            end
            if (s_grant) begin
                check("grant_addr", 64'(s_addr), 64'(model_pc));
                pend_q.push_back('{addr: model_pc, due: cyc + lat, epoch: epoch});
                model_pc += 32'd4;
            end
            if (bus.mem_rvalid_i) begin
                r = pend_q.pop_front();
                if (r.epoch == epoch && !redir_cfg)
                    exp_q.push_back('{pc: r.addr, inst: mem_word(r.addr)});
            end
            if (redir_cfg) begin
                epoch++;
                exp_q.delete();
                model_pc = redir_pc_cfg & ~32'd3;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_cfg   = 1'b1;
        redir_cfg = 1'b0;
        gnt_cfg   = 1'b0;
        ready_cfg = 1'b0;
        repeat (n) step();
        rst_cfg = 1'b0;
    endtask

    // Run until the first pop (bounded); returns its pc or 0 on timeout.
    task automatic first_pop(input int budget, output logic [31:0] pc);
        pc = '0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_pop) begin
                pc = s_pc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          rel, first, npops, ng, gap0, gap2;
        logic [31:0] pcs [4];
        logic [31:0] pc, gaddr;
        logic        got_ga;

        bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.inst_ready_i = 1'b0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

        // Reset state
        do_reset(3);
        check("rst_req", 64'(s_req), 64'd0);
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_inst", 64'(s_inst), 64'd0);
        check("rst_pc", 64'(s_pc), 64'd0);

        // Streaming: grant every cycle, 1-cycle memory, core always ready
        gnt_cfg = 1'b1; ready_cfg = 1'b1; lat = 1;
        rel = cyc; first = -1; npops = 0; gap0 = 0; gap2 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_valid && first < 0) first = s_cyc - rel + 1;
            if (s_pop && npops < 3) begin
                pcs[npops] = s_pc;
                if (npops == 0) gap0 = s_cyc;
                if (npops == 2) gap2 = s_cyc;
                npops++;
            end
        end
        check("first_valid_lat", 64'(first), 64'd3);
        check("seq_pc0", 64'(pcs[0]), 64'h8000_0000);
        check("seq_pc1", 64'(pcs[1]), 64'h8000_0004);
        check("seq_pc2", 64'(pcs[2]), 64'h8000_0008);
        check("seq_back2back", 64'(gap2 - gap0), 64'd2);

        // Core stalled: fill to DEPTH, then the request must drop
        do_reset(2);
        gnt_cfg = 1'b1; ready_cfg = 1'b0; lat = 1; ng = 0;
        repeat (10) begin
            step();
            if (s_grant) ng++;
        end
        check("stall_grants", 64'(ng), 64'd4);
        check("stall_req_low", 64'(s_req), 64'd0);
        check("stall_valid", 64'(s_valid), 64'd1);
        ready_cfg = 1'b1; npops = 0; got_ga = 1'b0; gaddr = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_pop && npops < 4) begin
                pcs[npops] = s_pc;
                npops++;
            end
            if (s_grant && !got_ga) begin
                gaddr  = s_addr;
                got_ga = 1'b1;
            end
        end
        check("drain_npops", 64'(npops), 64'd4);
        for (int k = 0; k < 4; k++) check("drain_pc", 64'(pcs[k]), 64'(RST_PC + 32'(4 * k)));
        check("resume_addr", 64'(gaddr), 64'h8000_0010);

        // Latency 3, redirect with two requests in flight
        do_reset(2);
        lat = 3; ready_cfg = 1'b1; gnt_cfg = 1'b1;
        step(); step();
        gnt_cfg = 1'b0; redir_cfg = 1'b1; redir_pc_cfg = 32'h8000_0100;
        step();
        redir_cfg = 1'b0; gnt_cfg = 1'b1;
        first_pop(20, pc);
        check("redir_l3_pc", 64'(pc), 64'h8000_0100);

        // Redirect coinciding with a grant and an rvalid, one request outstanding
        do_reset(2);
        lat = 1; ready_cfg = 1'b1; gnt_cfg = 1'b1;
        step();
        redir_cfg = 1'b1; redir_pc_cfg = 32'h8000_0200;
        step();
        redir_cfg = 1'b0;
        first_pop(20, pc);
        check("redir_same_pc", 64'(pc), 64'h8000_0200);

        // Unaligned redirect target
        repeat (3) step();
        redir_cfg = 1'b1; redir_pc_cfg = 32'h8000_0102;
        step();
        redir_cfg = 1'b0;
        step();
        check("mask_addr", 64'(s_addr), 64'h8000_0100);
        check("mask_req", 64'(s_req), 64'd1);
        first_pop(20, pc);
        check("mask_pc", 64'(pc), 64'h8000_0100);

        // PC wrap-around
        redir_cfg = 1'b1; redir_pc_cfg = 32'hFFFF_FFF8;
        step();
        redir_cfg = 1'b0; npops = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_pop && npops < 3) begin
                pcs[npops] = s_pc;
                npops++;
            end
        end
        check("wrap_pc0", 64'(pcs[0]), 64'hFFFF_FFF8);
        check("wrap_pc2", 64'(pcs[2]), 64'h0000_0000);

        // Reset in the middle of a stream with requests in flight
        do_reset(2);
        lat = 3; ready_cfg = 1'b0; gnt_cfg = 1'b1;
        repeat (6) step();
        check("pre_rst_valid", 64'(s_valid), 64'd1);
        check("pre_rst_outst", 64'(dut.outstanding_q != '0), 64'd1);
        rst_cfg = 1'b1;
        step();
        check("midrst_valid", 64'(s_valid), 64'd0);
        check("midrst_req", 64'(s_req), 64'd0);
        check("midrst_inst", 64'(s_inst), 64'd0);
        check("midrst_pc", 64'(s_pc), 64'd0);
        rst_cfg = 1'b0; ready_cfg = 1'b1; lat = 1;
        step();
        check("midrst_addr", 64'(s_addr), 64'(RST_PC));
        first_pop(20, pc);
        check("midrst_first_pc", 64'(pc), 64'(RST_PC));

        // Random traffic with occasional redirects
        for (int i = 0; i < 300; i++) begin
            gnt_cfg      = ($urandom_range(0, 3) != 0);
            ready_cfg    = ($urandom_range(0, 3) != 0);
            lat          = $urandom_range(1, 4);
            redir_cfg    = ($urandom_range(0, 29) == 0);
            redir_pc_cfg = $urandom;
            step();
        end
        redir_cfg = 1'b0; gnt_cfg = 1'b0; ready_cfg = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (pend_q.size() == 0 && exp_q.size() == 0) break;
            step();
        end
        check("drain_left", 64'(pend_q.size() + exp_q.size()), 64'd0);
        step();
        check("drain_valid", 64'(s_valid), 64'd0);
        check("drain_inst", 64'(s_inst), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
